// File: rtl/trng_pkg.sv
// trng_pkg: shared types and helpers for the TRNG health reader.
// Holds the 2-bit FSM state encoding and the counter-width helper that the
// health-test counters use.
package trng_pkg;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1,
        ALARM  = 2'd2
    } trng_state_t;

    // Number of bits needed to hold any value from 0 up to cutoff inclusive.
    function automatic int cnt_width(input int cutoff);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if (int'(32'd1 << i) <= cutoff) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/trng_word_fifo.sv
// trng_word_fifo: synchronous show-ahead FIFO for health-checked TRNG words.
// o_dat always shows the head entry. Pushes are ignored when full and pops
// are ignored when empty. Flush empties the buffer and overrides a push or
// pop in the same cycle. DEPTH must be a power of two, so the pointers wrap
// naturally.
module trng_word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_dat,
    output logic [WIDTH-1:0]         o_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_fill
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      fill_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Status flags and the qualified push/pop strobes.
    always_comb begin
        o_full    = (fill_r == (AW+1)'(DEPTH));
        o_empty   = (fill_r == '0);
        push_ok_s = i_push & ~o_full;
        pop_ok_s  = i_pop & ~o_empty;
    end

    // Read/write pointers and the occupancy count.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            fill_r   <= '0;
        end else if (i_flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            fill_r   <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   fill_r <= fill_r + (AW+1)'(1);
                2'b01:   fill_r <= fill_r - (AW+1)'(1);
                default: fill_r <= fill_r;
            endcase
        end
    end

    // Word storage. It is cleared on reset, so o_dat starts at zero.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s && !i_flush) begin
            mem_r[wr_ptr_r] <= i_dat;
        end
    end

    assign o_dat  = mem_r[rd_ptr_r];
    assign o_fill = fill_r;

endmodule

// File: rtl/trng_health_reader.sv
// trng_health_reader: consumer end of the TRNG word interface.
// Each word from the source is acknowledged with a same-cycle read strobe.
// The reader runs a repetition-count test and an adaptive-proportion test on
// every accepted word. Healthy words after warm-up go into a show-ahead FIFO.
// A failed test latches an alarm until i_clear_alarm is pulsed.
// Optional build macro TRNG_HEALTH_READER_STATS_EN adds a drop counter and
// sticky failure-cause flags.
module trng_health_reader
    import trng_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int WARMUP_WORDS = 4,
    parameter int RCT_CUTOFF   = 3,
    parameter int APT_WINDOW   = 64,
    parameter int APT_CUTOFF   = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [WIDTH-1:0]              i_src_dat,
    input  logic                          i_src_valid,
    output logic                          o_src_read,
    output logic [WIDTH-1:0]              o_dat,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_alarm,
    input  logic                          i_clear_alarm,
    output logic [$clog2(FIFO_DEPTH):0]   o_fill
`ifdef TRNG_HEALTH_READER_STATS_EN
    ,
    output logic [15:0]                   o_drop_cnt,
    output logic                          o_fail_rct,
    output logic                          o_fail_apt
`endif
);

    localparam int RCT_W = cnt_width(RCT_CUTOFF);
    localparam int APT_W = cnt_width(APT_CUTOFF);
    localparam int WRM_W = cnt_width(WARMUP_WORDS);
    localparam int WIN_W = $clog2(APT_WINDOW);

    localparam logic [RCT_W-1:0] RCT_MAX  = RCT_W'(RCT_CUTOFF);
    localparam logic [APT_W-1:0] APT_MAX  = APT_W'(APT_CUTOFF);
    localparam logic [WRM_W-1:0] WRM_LAST = WRM_W'(WARMUP_WORDS - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(APT_WINDOW - 1);

    trng_state_t      state_r;
    trng_state_t      state_nxt_s;
    logic             accept_s;
    logic             take_s;
    logic             fail_s;
    logic             clear_s;
    logic             push_s;
    logic             flush_s;
    logic             full_s;
    logic             empty_s;

    logic [WIDTH-1:0] last_word_r;
    logic [RCT_W-1:0] rep_r;
    logic [RCT_W-1:0] rep_nxt_s;
    logic             rct_fail_s;
    logic [WIDTH-1:0] ref_r;
    logic [WIDTH-1:0] ref_nxt_s;
    logic [APT_W-1:0] match_r;
    logic [APT_W-1:0] match_nxt_s;
    logic [WIN_W-1:0] win_r;
    logic [WIN_W-1:0] win_nxt_s;
    logic             apt_fail_s;
    logic [WRM_W-1:0] warm_r;

    // RCT: a zero count means there is no previous word, so the first word counts as a fresh run.
    always_comb begin
        rep_nxt_s = RCT_W'(1);
        if ((rep_r != '0) && (i_src_dat == last_word_r)) begin
            if (rep_r != RCT_MAX) begin
                rep_nxt_s = rep_r + RCT_W'(1);
            end else begin
                rep_nxt_s = rep_r;
            end
        end else begin
            rep_nxt_s = RCT_W'(1);
        end
        rct_fail_s = (rep_nxt_s >= RCT_MAX);
    end

    // APT: the first word of each window becomes the reference; later matches are counted.
    always_comb begin
        ref_nxt_s   = ref_r;
        match_nxt_s = match_r;
        if (win_r == '0) begin
            ref_nxt_s   = i_src_dat;
            match_nxt_s = APT_W'(1);
        end else if (i_src_dat == ref_r) begin
            if (match_r != APT_MAX) begin
                match_nxt_s = match_r + APT_W'(1);
            end else begin
                match_nxt_s = match_r;
            end
        end else begin
            match_nxt_s = match_r;
        end
        apt_fail_s = (match_nxt_s >= APT_MAX);
        if (win_r == WIN_LAST) begin
            win_nxt_s = '0;
        end else begin
            win_nxt_s = win_r + WIN_W'(1);
        end
    end

    // Source handshake, next-state selection, FIFO push and flush-on-alarm.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            WARMUP:  accept_s = 1'b1;
            RUN:     accept_s = ~full_s;
            ALARM:   accept_s = 1'b0;
            default: accept_s = 1'b0;
        endcase
        take_s  = i_src_valid & accept_s;
        fail_s  = take_s & (rct_fail_s | apt_fail_s);
        clear_s = (state_r == ALARM) & i_clear_alarm;
        case (state_r)
            WARMUP: begin
                if (fail_s) begin
                    state_nxt_s = ALARM;
                end else if (take_s && (warm_r == WRM_LAST)) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = WARMUP;
                end
            end
            RUN: begin
                if (fail_s) begin
                    state_nxt_s = ALARM;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            ALARM: begin
                if (clear_s) begin
                    state_nxt_s = WARMUP;
                end else begin
                    state_nxt_s = ALARM;
                end
            end
            default: state_nxt_s = WARMUP;
        endcase
        push_s  = take_s & (state_r == RUN) & ~fail_s;
        flush_s = (state_nxt_s == ALARM) & (state_r != ALARM);
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= WARMUP;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Health-test state. It advances on every accepted word and is wiped by an alarm clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            last_word_r <= '0;
            rep_r       <= '0;
            ref_r       <= '0;
            match_r     <= '0;
            win_r       <= '0;
        end else if (clear_s) begin
            last_word_r <= '0;
            rep_r       <= '0;
            ref_r       <= '0;
            match_r     <= '0;
            win_r       <= '0;
        end else if (take_s) begin
            last_word_r <= i_src_dat;
            rep_r       <= rep_nxt_s;
            ref_r       <= ref_nxt_s;
            match_r     <= match_nxt_s;
            win_r       <= win_nxt_s;
        end
    end

    // Warm-up word counter. It restarts for the next warm-up when RUN is entered.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            warm_r <= '0;
        end else if (clear_s) begin
            warm_r <= '0;
        end else if (take_s && (state_r == WARMUP)) begin
            if (state_nxt_s == RUN) begin
                warm_r <= '0;
            end else begin
                warm_r <= warm_r + WRM_W'(1);
            end
        end
    end

    trng_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (push_s),
        .i_pop     (i_ready),
        .i_flush   (flush_s),
        .i_dat     (i_src_dat),
        .o_dat     (o_dat),
        .o_full    (full_s),
        .o_empty   (empty_s),
        .o_fill    (o_fill)
    );

    assign o_src_read = take_s;
    assign o_valid    = ~empty_s;
    assign o_alarm    = (state_r == ALARM);

`ifdef TRNG_HEALTH_READER_STATS_EN
    logic [15:0] drop_cnt_r;
    logic        fail_rct_r;
    logic        fail_apt_r;

    // Saturating count of source words lost in RUN because the FIFO was full.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            drop_cnt_r <= 16'd0;
        end else if ((state_r == RUN) && i_src_valid && !accept_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
        end
    end

    // Sticky failure-cause flags, cleared together with the alarm.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fail_rct_r <= 1'b0;
            fail_apt_r <= 1'b0;
        end else if (clear_s) begin
            fail_rct_r <= 1'b0;
            fail_apt_r <= 1'b0;
        end else begin
            if (take_s && rct_fail_s) begin
                fail_rct_r <= 1'b1;
            end
            if (take_s && apt_fail_s) begin
                fail_apt_r <= 1'b1;
            end
        end
    end

    assign o_drop_cnt = drop_cnt_r;
    assign o_fail_rct = fail_rct_r;
    assign o_fail_apt = fail_apt_r;
`endif

endmodule

// File: tb/tb_trng_health_reader.sv
// tb_trng_health_reader: directed self-checking bench for trng_health_reader.
// Stats outputs are checked when TRNG_HEALTH_READER_STATS_EN is defined.
module tb_trng_health_reader;
    import trng_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic [7:0] i_src_dat;
    logic       i_src_valid;
    logic       o_src_read;
    logic [7:0] o_dat;
    logic       o_valid;
    logic       i_ready;
    logic       o_alarm;
    logic       i_clear_alarm;
    logic [2:0] o_fill;
`ifdef TRNG_HEALTH_READER_STATS_EN
    logic [15:0] o_drop_cnt;
    logic        o_fail_rct;
    logic        o_fail_apt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    trng_health_reader dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_src_dat     (i_src_dat),
        .i_src_valid   (i_src_valid),
        .o_src_read    (o_src_read),
        .o_dat         (o_dat),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_alarm       (o_alarm),
        .i_clear_alarm (i_clear_alarm),
        .o_fill        (o_fill)
`ifdef TRNG_HEALTH_READER_STATS_EN
        ,
        .o_drop_cnt    (o_drop_cnt),
        .o_fail_rct    (o_fail_rct),
        .o_fail_apt    (o_fail_apt)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one word for a single cycle; rd reports the read strobe seen in that cycle.
    task automatic send(input logic [7:0] w, output logic rd);
        i_src_dat   = w;
        i_src_valid = 1'b1;
        @(negedge i_clk);
        rd = o_src_read;
        @(posedge i_clk);
        #1;
        i_src_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    logic       rd;
    logic [7:0] w;

    initial begin
        i_reset_n     = 1'b0;
        i_src_dat     = 8'h00;
        i_src_valid   = 1'b0;
        i_ready       = 1'b0;
        i_clear_alarm = 1'b0;
        tick(2);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_fill",  32'(o_fill),  32'd0);
        check("rst_alarm", 32'(o_alarm), 32'd0);
        check("rst_dat",   32'(o_dat),   32'd0);
        i_reset_n = 1'b1;
        tick(1);

        // Warm-up: four distinct words are acknowledged but not buffered.
        for (int i = 0; i < 4; i++) begin
            w = 8'h01 + 8'(i);
            send(w, rd);
            check("wu_read",  32'(rd),      32'd1);
            check("wu_valid", 32'(o_valid), 32'd0);
        end
        check("wu_state_run", 32'(dut.state_r), 32'(RUN));

        // Streaming through with the consumer ready.
        i_ready = 1'b1;
        send(8'h11, rd);
        check("s1_read",  32'(rd),      32'd1);
        check("s1_valid", 32'(o_valid), 32'd1);
        check("s1_dat",   32'(o_dat),   32'h11);
        check("s1_fill",  32'(o_fill),  32'd1);
        send(8'h22, rd);
        check("s2_read",  32'(rd),      32'd1);
        check("s2_dat",   32'(o_dat),   32'h22);
        check("s2_fill",  32'(o_fill),  32'd1);
        tick(1);
        check("s_drain_valid", 32'(o_valid), 32'd0);
        check("s_drain_fill",  32'(o_fill),  32'd0);

        // Fill the FIFO with the consumer stalled; the fifth word is refused.
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = 8'h31 + 8'(i);
            send(w, rd);
            check("full_read", 32'(rd), (i < 4) ? 32'd1 : 32'd0);
        end
        check("full_fill", 32'(o_fill), 32'd4);
        check("full_head", 32'(o_dat),  32'h31);
`ifdef TRNG_HEALTH_READER_STATS_EN
        check("drop1", 32'(o_drop_cnt), 32'd1);
`endif
        // A pop in the same cycle does not open a slot for the incoming word.
        i_ready = 1'b1;
        send(8'h36, rd);
        check("fullpop_read", 32'(rd),     32'd0);
        check("fullpop_fill", 32'(o_fill), 32'd3);
        check("fullpop_head", 32'(o_dat),  32'h32);
`ifdef TRNG_HEALTH_READER_STATS_EN
        check("drop2", 32'(o_drop_cnt), 32'd2);
`endif
        tick(3);
        check("drain_fill", 32'(o_fill), 32'd0);
        i_ready = 1'b0;

        // Repetition count: the third identical word raises the alarm and is not buffered.
        send(8'h5A, rd);
        check("rct1_fill", 32'(o_fill), 32'd1);
        send(8'h5A, rd);
        check("rct2_fill",  32'(o_fill),  32'd2);
        check("rct2_alarm", 32'(o_alarm), 32'd0);
        send(8'h5A, rd);
        check("rct3_read",  32'(rd),      32'd1);
        check("rct3_alarm", 32'(o_alarm), 32'd1);
        check("rct3_valid", 32'(o_valid), 32'd0);
        check("rct3_fill",  32'(o_fill),  32'd0);
        send(8'h77, rd);
        check("alarm_noread", 32'(rd),      32'd0);
        check("alarm_held",   32'(o_alarm), 32'd1);
`ifdef TRNG_HEALTH_READER_STATS_EN
        check("rct_flag",   32'(o_fail_rct), 32'd1);
        check("rct_noapt",  32'(o_fail_apt), 32'd0);
        check("drop_alarm", 32'(o_drop_cnt), 32'd2);
`endif

        // Clear the alarm: warm-up restarts with fresh test state.
        i_clear_alarm = 1'b1;
        tick(1);
        i_clear_alarm = 1'b0;
        check("clr_alarm", 32'(o_alarm),    32'd0);
        check("clr_state", 32'(dut.state_r), 32'(WARMUP));
`ifdef TRNG_HEALTH_READER_STATS_EN
        check("clr_rct_flag", 32'(o_fail_rct), 32'd0);
`endif

        // One 64-word window with only 7 reference matches (C3 at even slots 0..12).
        i_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            w = ((i % 2 == 0) && (i < 14)) ? 8'hC3 : (8'h40 + 8'(i));
            send(w, rd);
            if (i == 3) begin
                check("apt7_wu_valid", 32'(o_valid),     32'd0);
                check("apt7_wu_state", 32'(dut.state_r), 32'(RUN));
            end
            if (i == 4) begin
                check("apt7_push_valid", 32'(o_valid), 32'd1);
                check("apt7_push_dat",   32'(o_dat),   32'hC3);
            end
        end
        check("apt7_alarm", 32'(o_alarm), 32'd0);

        // The next C3 opens a new window instead of being the 8th match.
        send(8'hC3, rd);
        check("apt_restart_alarm", 32'(o_alarm), 32'd0);
        check("apt_restart_dat",   32'(o_dat),   32'hC3);

        // Seven more non-consecutive C3 words bring this window to 8 matches.
        for (int j = 0; j < 7; j++) begin
            w = 8'h80 + 8'(j);
            send(w, rd);
            send(8'hC3, rd);
            check("apt8_alarm", 32'(o_alarm), (j == 6) ? 32'd1 : 32'd0);
        end
        check("apt8_read",  32'(rd),      32'd1);
        check("apt8_valid", 32'(o_valid), 32'd0);
`ifdef TRNG_HEALTH_READER_STATS_EN
        check("apt_flag",   32'(o_fail_apt), 32'd1);
        check("apt_no_rct", 32'(o_fail_rct), 32'd0);
`endif

        // Recover, buffer three words, then reset asynchronously mid-cycle.
        i_clear_alarm = 1'b1;
        tick(1);
        i_clear_alarm = 1'b0;
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = 8'h90 + 8'(i);
            send(w, rd);
        end
        check("rec_wu_valid", 32'(o_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            w = 8'hA0 + 8'(i);
            send(w, rd);
        end
        check("rec_fill", 32'(o_fill), 32'd3);
        check("rec_head", 32'(o_dat),  32'hA0);
        i_reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_fill",  32'(o_fill),  32'd0);
        check("arst_alarm", 32'(o_alarm), 32'd0);
        tick(1);
        i_reset_n = 1'b1;
        tick(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
